codec_sample_scheduler: RTL
===========================

Name: codec_sample_scheduler

Overview:
- Sequences the per-frame sample fetch for the AC97 playback path.
- On each codec frame it polls up to NUM_VOICES voice generators in fixed index order through a req/valid handshake, and accumulates their signed samples with saturation.
- It presents the mixed result to the codec's PCM_Playback_Left/Right on the following frame boundary.
- It sits between the note/voice players and ac97_if, and owns the only writes to the codec's playback inputs.

Parameters:
- NUM_VOICES, 3, number of voice requesters polled per frame (1..8).
- TIMEOUT, 16, max clk cycles to wait for voice_valid after a request before skipping that voice.
- SW, 16, sample width in bits, signed two's complement.

Ports:
- clk  in  1  system clock (same clock as codec ClkIn).
- reset  in  1  synchronous, active-high reset.
- new_frame  in  1  codec PCM_Playback_Accept level; a rising edge marks a frame boundary.
- voice_enable  in  NUM_VOICES  per-voice enable; sampled at each voice's SELECT step.
- voice_req  out  NUM_VOICES  one-hot, one-cycle request pulse to voice i.
- voice_sample  in  NUM_VOICES*SW  packed samples; voice i occupies bits [i*SW +: SW].
- voice_valid  in  NUM_VOICES  voice i presents a valid sample this cycle.
- pcm_left  out  SW  mixed sample to the codec left channel.
- pcm_right  out  SW  same value as pcm_left (mono mix).
- busy  out  1  high while a frame's fetch/mix is in progress.
- underrun  out  1  one-cycle pulse when a frame edge arrives before the mix completes.
- underrun_count  out  8  saturating count of underruns.

Behaviour:
- Reset (synchronous, active-high): pcm_left/right=0, pending=0, voice_req=0, busy=0, underrun=0, underrun_count=0, state=IDLE, edge-detect register=0.
- Reset mid-fetch aborts the fetch immediately; no req is issued in the cycle after reset.
- frame_edge = new_frame & ~new_frame_q, where new_frame_q is the registered new_frame.
- States: IDLE, SELECT, REQ, WAIT, DONE.
- On frame_edge in DONE:
  - pcm_left/right <= pending at that same posedge.
  - Clear the accumulator, idx=0, busy=1, go to SELECT.
- On frame_edge in IDLE (first frame after reset): pcm unchanged, start the fetch as above.
- On frame_edge in SELECT/REQ/WAIT (underrun):
  - pcm holds its previous value.
  - underrun=1 for that cycle; underrun_count increments, saturating at 255.
  - Abort the fetch, clear voice_req, restart at SELECT with idx=0.
- SELECT:
  - If idx==NUM_VOICES: pending <= sat(acc), busy=0, go to DONE.
  - Else if voice_enable[idx]: go to REQ.
  - Else idx++ and stay in SELECT (one cycle per skipped voice).
- REQ: voice_req[idx]=1 for exactly one cycle; timer=0; go to WAIT.
- WAIT:
  - If voice_valid[idx]: acc += sign_extend(sample_idx); idx++; go to SELECT.
  - Else if timer==TIMEOUT-1: skip the voice (contributes 0); idx++; go to SELECT.
  - Else timer++.
  - voice_valid of any non-selected voice is ignored.
  - voice_valid in the REQ cycle itself is ignored.
- Accumulator width is SW+3 signed.
- sat(): clamp to [-2^(SW-1), 2^(SW-1)-1].
- Latency: the mix fetched during frame k appears on pcm at the frame k+1 edge and is held constant until the next edge.
- All voices disabled → pending=0.
- new_frame held high: no further edges.
- Edges closer than the fetch time: every edge is an underrun.
- Worst-case fetch time: 2 + NUM_VOICES*(TIMEOUT+2) cycles.

Test Plan:
- Reset, then an edge with enable=3'b111 and voices returning 100, 200, -50 with valid one cycle after req. Required: req pulses in order 001, 010, 100; pending=250; pcm=0 until the second edge, then pcm_left=pcm_right=250.
- Saturation: voices 30000, 30000, 30000 → pcm=32767; voices -30000 ×3 → pcm=-32768.
- Enable=3'b010 only: exactly one req pulse, on bit 1; others never requested; pcm equals voice 1's sample.
- Voice 0 never asserts valid. Required: its req is followed by exactly TIMEOUT wait cycles, then voice 1 is requested; the mix excludes voice 0; no underrun.
- Frame edge issued 5 cycles after the previous edge while in WAIT. Required: underrun pulse of one cycle; underrun_count 0→1; pcm unchanged; fetch restarts at voice 0. Assert 300 underruns and check the count stops at 255.
- Assert reset during WAIT. Required: next cycle all outputs are 0, state is IDLE, and no voice_req is issued until the next frame edge.

Source files
------------

// File: rtl/codec_sample_scheduler.sv
// Purpose: per-frame voice sample fetch and saturating mix for the AC97 playback path.
// Latency: the mix fetched during frame k is driven on pcm at the frame k+1 edge.
// Backpressure: each voice gets TIMEOUT cycles to answer a request, then it is skipped.
module codec_sample_scheduler #(
    parameter int NUM_VOICES = 3,
    parameter int TIMEOUT    = 16,
    parameter int SW         = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     new_frame,
    input  logic [NUM_VOICES-1:0]    voice_enable,
    output logic [NUM_VOICES-1:0]    voice_req,
    input  logic [NUM_VOICES*SW-1:0] voice_sample,
    input  logic [NUM_VOICES-1:0]    voice_valid,
    output logic [SW-1:0]            pcm_left,
    output logic [SW-1:0]            pcm_right,
    output logic                     busy,
    output logic                     underrun,
    output logic [7:0]               underrun_count
);

    localparam int IW = $clog2(NUM_VOICES + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int AW = SW + 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_REQ    = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Clamp bounds of the SW-bit output expressed in accumulator width.
    localparam logic signed [AW-1:0] ACC_MAX = {4'b0000, {(SW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {4'b1111, {(SW-1){1'b0}}};

    logic [2:0]           state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [SW-1:0]        pending_q, pending_d;
    logic [SW-1:0]        pcm_q, pcm_d;
    logic                 busy_q, busy_d;
    logic                 underrun_q, underrun_d;
    logic [7:0]           ucount_q, ucount_d;
    logic                 new_frame_q;

    logic                 frame_edge;
    logic                 sel_en;
    logic                 sel_vld;
    logic [SW-1:0]        sel_sample;
    logic [SW-1:0]        acc_sat;

    assign frame_edge = new_frame & ~new_frame_q;

    // Pick the enable, valid and sample of the voice addressed by idx; idx==NUM_VOICES selects nothing.
    always_comb begin
        sel_en     = 1'b0;
        sel_vld    = 1'b0;
        sel_sample = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (idx_q == IW'(i)) begin
                sel_en     = voice_enable[i];
                sel_vld    = voice_valid[i];
                sel_sample = voice_sample[i*SW +: SW];
            end
        end
    end

    // One-hot request to the addressed voice, only while in REQ.
    always_comb begin
        voice_req = '0;
        if (state_q == ST_REQ) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (idx_q == IW'(i)) begin
                    voice_req[i] = 1'b1;
                end
            end
        end
    end

    // Saturate the wide accumulator to the SW-bit signed output range.
    always_comb begin
        if (acc_q > ACC_MAX) begin
            acc_sat = ACC_MAX[SW-1:0];
        end else if (acc_q < ACC_MIN) begin
            acc_sat = ACC_MIN[SW-1:0];
        end else begin
            acc_sat = acc_q[SW-1:0];
        end
    end

    // Next-state logic: a frame edge preempts whatever step the fetch is on.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        acc_d      = acc_q;
        pending_d  = pending_q;
        pcm_d      = pcm_q;
        busy_d     = busy_q;
        underrun_d = 1'b0;
        ucount_d   = ucount_q;
        if (frame_edge) begin
            if (state_q == ST_DONE) begin
                pcm_d = pending_q;
            end else if (state_q != ST_IDLE) begin
                // Previous mix never finished: keep pcm and flag the underrun.
                underrun_d = 1'b1;
                if (ucount_q != 8'hFF) begin
                    ucount_d = ucount_q + 8'd1;
                end
            end
            acc_d   = '0;
            idx_d   = '0;
            timer_d = '0;
            busy_d  = 1'b1;
            state_d = ST_SELECT;
        end else begin
            case (state_q)
                ST_SELECT: begin
                    if (idx_q == IW'(NUM_VOICES)) begin
                        pending_d = acc_sat;
                        busy_d    = 1'b0;
                        state_d   = ST_DONE;
                    end else if (sel_en) begin
                        state_d = ST_REQ;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                ST_REQ: begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (sel_vld) begin
                        acc_d   = acc_q + {{3{sel_sample[SW-1]}}, sel_sample};
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_SELECT;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_SELECT;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_IDLE, ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers with synchronous reset; reset aborts any fetch in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            timer_q     <= '0;
            acc_q       <= '0;
            pending_q   <= '0;
            pcm_q       <= '0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
            ucount_q    <= 8'd0;
            new_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            acc_q       <= acc_d;
            pending_q   <= pending_d;
            pcm_q       <= pcm_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
            ucount_q    <= ucount_d;
            new_frame_q <= new_frame;
        end
    end

    assign pcm_left       = pcm_q;
    assign pcm_right      = pcm_q;
    assign busy           = busy_q;
    assign underrun       = underrun_q;
    assign underrun_count = ucount_q;

endmodule
